team_04_wb_master_arbiter: RTL and testbench
============================================

TEAM_04_WB_MASTER_ARBITER -- requirements
Module: team_04_wb_master_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16'd1000, ACTIVE-state cycles without ACK_I before abort (legal 1..65535).
REQ-002 clk_i  in  1  single block clock (bus clock).
REQ-003 nrst  in  1  reset, asynchronous, active-low.
REQ-004 req_i  in  2  per-requester transfer request, bit n = requester n.
REQ-005 we_i  in  2  per-requester write enable (1 = write).
REQ-006 adr_i  in  64  requester n address at [32n+31:32n].
REQ-007 wdat_i  in  64  requester n write data at [32n+31:32n].
REQ-008 sel_i  in  8  requester n byte select at [4n+3:4n].
REQ-009 ack_o  out  2  one-cycle completion pulse per requester.
REQ-010 err_o  out  2  one-cycle timeout-abort pulse per requester.
REQ-011 rdat_o  out  32  read data of last completed transfer, shared.
REQ-012 gnt_o  out  2  one-hot current grant, 0 when idle.
REQ-013 ADR_O/DAT_O/SEL_O/WE_O/STB_O/CYC_O  out  32/32/4/1/1/1  Wishbone master outputs, all registered.
REQ-014 DAT_I  in  32  Wishbone read data.
REQ-015 ACK_I  in  1  Wishbone acknowledge.

Function
REQ-016 FSM states SHALL be IDLE, ACTIVE, DONE.
REQ-017 IDLE: if req_i != 0, SHALL grant one requester, latch its we/adr/wdat/sel into ADR_O/DAT_O/SEL_O/WE_O, set CYC_O=STB_O=1 and gnt_o one-hot on the next edge, go to ACTIVE.
REQ-018 Arbitration SHALL be round-robin: sole requester wins; both requesting -> requester not granted last wins; last-grant register resets to 1 so requester 0 wins the first tie.
REQ-019 ACTIVE: CYC_O/STB_O/address/data/sel/we SHALL hold stable until ACK_I sampled high.
REQ-020 ACK_I high in ACTIVE: next edge SHALL clear CYC_O/STB_O, capture DAT_I into rdat_o (reads only; writes leave rdat_o unchanged), pulse ack_o[granted] for exactly one cycle, go to DONE.
REQ-021 DONE SHALL last one cycle with gnt_o=0, then return to IDLE; minimum spacing between transfers is therefore 3 cycles (request sampled -> ACTIVE -> DONE).
REQ-022 Requester dropping req_i during ACTIVE SHALL NOT abort the transfer; ack_o still pulses.
REQ-023 Requester is required to deassert req_i in the cycle ack_o/err_o is high; a req_i still high in IDLE is a new request.
REQ-024 ACK_I outside ACTIVE SHALL be ignored.
REQ-025 Granted requester's inputs SHALL be sampled only at the IDLE->ACTIVE edge; later changes ignored.

Reset
REQ-026 nrst low SHALL asynchronously force: state IDLE, all Wishbone outputs 0, ack_o=0, err_o=0, gnt_o=0, rdat_o=0, last-grant=1, timeout counter=0.
REQ-027 Reset mid-ACTIVE SHALL drop CYC_O/STB_O immediately with no ack_o/err_o pulse.

Configuration
REQ-028 Macro TEAM_04_ARB_TIMEOUT_EN defined: 16-bit counter SHALL clear on entering ACTIVE, increment each ACTIVE cycle; when it equals TIMEOUT_CYCLES with ACK_I low, next edge clears CYC_O/STB_O, pulses err_o[granted] one cycle, leaves rdat_o unchanged, enters DONE; ACK_I in the same cycle as expiry wins (normal completion).
REQ-029 Macro undefined: no counter; ACTIVE waits indefinitely; err_o tied 0.

Verification
REQ-030 Read: req_i=01, we_i=00, adr_i[31:0]=0x3000_0010; slave ACKs 2 cycles after STB_O with DAT_I=0xDEAD_BEEF -> rdat_o=0xDEAD_BEEF, ack_o=01 for one cycle, CYC_O low same edge.
REQ-031 Tie: req_i=11 held continuously from reset -> grant order 01,10,01,10 across four transfers, each separated by one DONE cycle.
REQ-032 Write: requester 1 write adr 0x3000_0004, wdat 0x1234_5678, sel 0xF -> ADR_O/DAT_O/SEL_O/WE_O match and hold until ACK_I; rdat_o unchanged.
REQ-033 Timeout (macro on, TIMEOUT_CYCLES=4): no ACK_I -> CYC_O drops after 4 ACTIVE cycles, err_o=01 one cycle, ack_o stays 0; macro off -> CYC_O stays high 100 cycles.
REQ-034 nrst pulsed low mid-ACTIVE -> CYC_O/STB_O=0 asynchronously, no ack/err pulse; next req_i=11 grants requester 0.
REQ-035 req_i dropped during ACTIVE, then ACK_I -> ack_o still pulses; stray ACK_I in IDLE -> no output change.

Source files
------------

// File: rtl/team_04_wb_master_arbiter.sv
// rtl/team_04_wb_master_arbiter.sv - two-requester round-robin Wishbone master arbiter
// Optional ACTIVE-state timeout abort is enabled by defining TEAM_04_ARB_TIMEOUT_EN.
module team_04_wb_master_arbiter #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
  input  logic        clk_i,
  input  logic        nrst,
  input  logic [1:0]  req_i,
  input  logic [1:0]  we_i,
  input  logic [63:0] adr_i,
  input  logic [63:0] wdat_i,
  input  logic [7:0]  sel_i,
  output logic [1:0]  ack_o,
  output logic [1:0]  err_o,
  output logic [31:0] rdat_o,
  output logic [1:0]  gnt_o,
  output logic [31:0] ADR_O,
  output logic [31:0] DAT_O,
  output logic [3:0]  SEL_O,
  output logic        WE_O,
  output logic        STB_O,
  output logic        CYC_O,
  input  logic [31:0] DAT_I,
  input  logic        ACK_I
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

  state_t r_state;
  logic   r_last;
  logic   w_pick;

  // On a tie the requester that did not win last time takes the bus.
  assign w_pick = (req_i == 2'b11) ? ~r_last : req_i[1];

`ifdef TEAM_04_ARB_TIMEOUT_EN
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_next;
  logic        w_expire;

  // The compare uses the post-increment count so that exactly TIMEOUT_CYCLES
  // ACTIVE cycles elapse before the abort edge.
  assign w_cnt_next = r_cnt + 16'd1;
  assign w_expire   = (w_cnt_next == TIMEOUT_CYCLES);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign err_o = 2'b00;
`endif

  always_ff @(posedge clk_i or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;
      ack_o   <= 2'b00;
      rdat_o  <= 32'h0;
      gnt_o   <= 2'b00;
      ADR_O   <= 32'h0;
      DAT_O   <= 32'h0;
      SEL_O   <= 4'h0;
      WE_O    <= 1'b0;
      STB_O   <= 1'b0;
      CYC_O   <= 1'b0;
`ifdef TEAM_04_ARB_TIMEOUT_EN
      err_o   <= 2'b00;
      r_cnt   <= 16'h0;
`endif
    end else begin
      ack_o <= 2'b00;
`ifdef TEAM_04_ARB_TIMEOUT_EN
      err_o <= 2'b00;
`endif
      case (r_state)
        S_IDLE: begin
          if (req_i != 2'b00) begin
            ADR_O   <= w_pick ? adr_i[63:32]  : adr_i[31:0];
            DAT_O   <= w_pick ? wdat_i[63:32] : wdat_i[31:0];
            SEL_O   <= w_pick ? sel_i[7:4]    : sel_i[3:0];
            WE_O    <= we_i[w_pick];
            CYC_O   <= 1'b1;
            STB_O   <= 1'b1;
            gnt_o   <= w_pick ? 2'b10 : 2'b01;
            r_last  <= w_pick;
            r_state <= S_ACTIVE;
`ifdef TEAM_04_ARB_TIMEOUT_EN
            r_cnt   <= 16'h0;
`endif
          end
        end
        S_ACTIVE: begin
          if (ACK_I) begin
            CYC_O   <= 1'b0;
            STB_O   <= 1'b0;
            if (!WE_O) rdat_o <= DAT_I;
            ack_o   <= gnt_o;
            gnt_o   <= 2'b00;
            r_state <= S_DONE;
          end
`ifdef TEAM_04_ARB_TIMEOUT_EN
          else if (w_expire) begin
            CYC_O   <= 1'b0;
            STB_O   <= 1'b0;
            err_o   <= gnt_o;
            gnt_o   <= 2'b00;
            r_state <= S_DONE;
          end else begin
            r_cnt   <= w_cnt_next;
          end
`endif
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_team_04_wb_master_arbiter.sv
// tb/tb_team_04_wb_master_arbiter.sv - directed self-checking bench for team_04_wb_master_arbiter
module tb_team_04_wb_master_arbiter;

  logic        clk_i = 1'b0;
  logic        nrst;
  logic [1:0]  req_i;
  logic [1:0]  we_i;
  logic [63:0] adr_i;
  logic [63:0] wdat_i;
  logic [7:0]  sel_i;
  logic [1:0]  ack_o;
  logic [1:0]  err_o;
  logic [31:0] rdat_o;
  logic [1:0]  gnt_o;
  logic [31:0] ADR_O;
  logic [31:0] DAT_O;
  logic [3:0]  SEL_O;
  logic        WE_O;
  logic        STB_O;
  logic        CYC_O;
  logic [31:0] DAT_I;
  logic        ACK_I;

  int n_tests = 0;
  int n_fail  = 0;

  team_04_wb_master_arbiter #(.TIMEOUT_CYCLES(16'd4)) dut (
    .clk_i(clk_i), .nrst(nrst), .req_i(req_i), .we_i(we_i), .adr_i(adr_i),
    .wdat_i(wdat_i), .sel_i(sel_i), .ack_o(ack_o), .err_o(err_o),
    .rdat_o(rdat_o), .gnt_o(gnt_o), .ADR_O(ADR_O), .DAT_O(DAT_O),
    .SEL_O(SEL_O), .WE_O(WE_O), .STB_O(STB_O), .CYC_O(CYC_O),
    .DAT_I(DAT_I), .ACK_I(ACK_I)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int low_cycles;
    nrst = 1'b0; req_i = 2'b00; we_i = 2'b00; adr_i = '0; wdat_i = '0;
    sel_i = '0; DAT_I = '0; ACK_I = 1'b0;
    tick(); tick();
    check("rst_cyc", CYC_O, 0);
    check("rst_stb", STB_O, 0);
    check("rst_gnt", gnt_o, 0);
    check("rst_rdat", rdat_o, 0);
    check("rst_ack", ack_o, 0);
    check("rst_err", err_o, 0);
    nrst = 1'b1;

    // Read from requester 0, request dropped mid-transfer, ACK two cycles after STB
    req_i = 2'b01; we_i = 2'b00; adr_i = 64'h0000_0000_3000_0010;
    tick();
    check("rd_cyc", CYC_O, 1);
    check("rd_stb", STB_O, 1);
    check("rd_gnt", gnt_o, 2'b01);
    check("rd_adr", ADR_O, 32'h3000_0010);
    check("rd_we", WE_O, 0);
    req_i = 2'b00;
    tick();
    check("rd_hold_cyc", CYC_O, 1);
    ACK_I = 1'b1; DAT_I = 32'hDEAD_BEEF;
    tick();
    check("rd_done_cyc", CYC_O, 0);
    check("rd_ack", ack_o, 2'b01);
    check("rd_rdat", rdat_o, 32'hDEAD_BEEF);
    check("rd_done_gnt", gnt_o, 0);
    ACK_I = 1'b0;
    tick();
    check("rd_ack_clr", ack_o, 0);

    // Fresh reset, then both requesting continuously: strict alternation from requester 0
    nrst = 1'b0; tick(); nrst = 1'b1;
    check("tie_rdat_rst", rdat_o, 0);
    req_i = 2'b11; we_i = 2'b00; adr_i = 64'h2000_0008_1000_0004;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("tie_gnt%0d", i), gnt_o, (i % 2 == 0) ? 2'b01 : 2'b10);
      ACK_I = 1'b1; DAT_I = 32'hCAFE_0000 + i;
      tick();
      check($sformatf("tie_ack%0d", i), ack_o, (i % 2 == 0) ? 2'b01 : 2'b10);
      check($sformatf("tie_done_gnt%0d", i), gnt_o, 0);
      ACK_I = 1'b0;
      if (i == 3) req_i = 2'b00;
      tick();
    end
    check("tie_rdat", rdat_o, 32'hCAFE_0003);

    // Write from requester 1; inputs changed after grant must not leak through
    req_i = 2'b10; we_i = 2'b10;
    adr_i = 64'h3000_0004_0BAD_0BAD; wdat_i = 64'h1234_5678_5555_AAAA; sel_i = 8'hF3;
    tick();
    check("wr_gnt", gnt_o, 2'b10);
    check("wr_adr", ADR_O, 32'h3000_0004);
    check("wr_dat", DAT_O, 32'h1234_5678);
    check("wr_sel", SEL_O, 4'hF);
    check("wr_we", WE_O, 1);
    req_i = 2'b00; adr_i = '1; wdat_i = '0; sel_i = '0; we_i = 2'b00;
    tick();
    check("wr_hold_adr", ADR_O, 32'h3000_0004);
    check("wr_hold_dat", DAT_O, 32'h1234_5678);
    check("wr_hold_we", WE_O, 1);
    ACK_I = 1'b1; DAT_I = 32'hAAAA_5555;
    tick();
    check("wr_ack", ack_o, 2'b10);
    check("wr_rdat_kept", rdat_o, 32'hCAFE_0003);
    ACK_I = 1'b0;
    tick();

    // Stray ACK while idle
    ACK_I = 1'b1; DAT_I = 32'h1111_1111;
    tick();
    check("stray_ack", ack_o, 0);
    check("stray_rdat", rdat_o, 32'hCAFE_0003);
    check("stray_cyc", CYC_O, 0);
    ACK_I = 1'b0;

    // Slave never answers
    req_i = 2'b01; we_i = 2'b00; adr_i = 64'h0000_0000_3000_0020;
    tick();
    req_i = 2'b00;
`ifdef TEAM_04_ARB_TIMEOUT_EN
    tick(); tick(); tick();
    check("to_cyc_before", CYC_O, 1);
    tick();
    check("to_cyc", CYC_O, 0);
    check("to_err", err_o, 2'b01);
    check("to_ack", ack_o, 0);
    check("to_rdat", rdat_o, 32'hCAFE_0003);
    tick();
    check("to_err_clr", err_o, 0);
`else
    low_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (CYC_O !== 1'b1 || err_o !== 2'b00) low_cycles++;
    end
    check("noto_cyc_held", low_cycles, 0);
    ACK_I = 1'b1;
    tick();
    check("noto_ack", ack_o, 2'b01);
    ACK_I = 1'b0;
    tick();
`endif

    // Asynchronous reset in the middle of a requester-0 transfer
    req_i = 2'b01; adr_i = 64'h0000_0000_3000_0030;
    tick();
    check("mid_cyc_pre", CYC_O, 1);
    req_i = 2'b00;
    #2 nrst = 1'b0;
    #1;
    check("mid_cyc", CYC_O, 0);
    check("mid_stb", STB_O, 0);
    check("mid_adr", ADR_O, 0);
    check("mid_gnt", gnt_o, 0);
    ACK_I = 1'b1;
    tick();
    check("mid_ack", ack_o, 0);
    check("mid_err", err_o, 0);
    ACK_I = 1'b0; nrst = 1'b1;
    req_i = 2'b11;
    tick();
    check("mid_tie_gnt", gnt_o, 2'b01);
    req_i = 2'b00;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
